// File: rtl/qaoa_kernel_sdiv_68s_23s_49_seq_if.sv
// Handshake and data bundle for the iterative signed divider.
// The divider itself uses the slave view; the producer/consumer side uses the master view.
interface qaoa_kernel_sdiv_68s_23s_49_seq_if #(
  parameter int din0_WIDTH = 68,
  parameter int din1_WIDTH = 23,
  parameter int dout_WIDTH = 49
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] quot;
  logic [din1_WIDTH-1:0] rem;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero, overflow
  );
endinterface

// File: rtl/qaoa_kernel_sdiv_68s_23s_49_seq.sv
// Radix-2 restoring signed divider: 68s / 23s -> 49s quotient (saturated) and 23s remainder.
// Magnitudes are divided MSB first, then signs and saturation are applied in a single fix-up cycle.
module qaoa_kernel_sdiv_68s_23s_49_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 68,
  parameter int din1_WIDTH = 23,
  parameter int dout_WIDTH = 49
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  qaoa_kernel_sdiv_68s_23s_49_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [6:0] CNT_LAST = 7'(din0_WIDTH - 1);
  // Largest quotient magnitudes representable for positive and negative results.
  localparam logic [din0_WIDTH-1:0] QPOS_LIM =
    {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic [din0_WIDTH-1:0] QNEG_LIM = QPOS_LIM + 1'b1;
  localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

  // ID tags the instance only and carries no logic.
  if (ID < 0) begin : g_id_tag
  end

  state_t                r_state;
  logic                  r_sign0;
  logic                  r_sign1;
  logic                  r_zero;
  logic [din0_WIDTH-1:0] r_work;
  logic [din1_WIDTH-1:0] r_dmag;
  logic [din1_WIDTH-1:0] r_prem;
  logic [6:0]            r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [dout_WIDTH-1:0] r_quot;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_dbz;
  logic                  r_ovf;

  logic [din0_WIDTH-1:0] w_abs0;
  logic [din1_WIDTH-1:0] w_abs1;
  logic [din1_WIDTH:0]   w_trial;
  logic                  w_fits;
  logic [din1_WIDTH-1:0] w_prem_next;
  logic                  w_qneg;
  logic                  w_ovf;
  logic [dout_WIDTH-1:0] w_qmag;
  logic [dout_WIDTH-1:0] w_quot_signed;
  logic [din1_WIDTH-1:0] w_rem_signed;

  // Two's-complement negate of the most negative value yields 2^(N-1) read as unsigned.
  assign w_abs0 = bus.din0[din0_WIDTH-1] ? (~bus.din0 + 1'b1) : bus.din0;
  assign w_abs1 = bus.din1[din1_WIDTH-1] ? (~bus.din1 + 1'b1) : bus.din1;

  // The working register shifts dividend bits out of the top and quotient bits in at the bottom.
  assign w_trial     = {r_prem, r_work[din0_WIDTH-1]};
  assign w_fits      = (w_trial >= {1'b0, r_dmag});
  assign w_prem_next = w_fits ? din1_WIDTH'(w_trial - {1'b0, r_dmag})
                              : w_trial[din1_WIDTH-1:0];

  assign w_qneg        = r_sign0 ^ r_sign1;
  assign w_ovf         = w_qneg ? (r_work > QNEG_LIM) : (r_work > QPOS_LIM);
  assign w_qmag        = r_work[dout_WIDTH-1:0];
  assign w_quot_signed = w_qneg ? (~w_qmag + 1'b1) : w_qmag;
  assign w_rem_signed  = r_sign0 ? (~r_prem + 1'b1) : r_prem;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sign0     <= 1'b0;
      r_sign1     <= 1'b0;
      r_zero      <= 1'b0;
      r_work      <= '0;
      r_dmag      <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sign0    <= bus.din0[din0_WIDTH-1];
            r_sign1    <= bus.din1[din1_WIDTH-1];
            r_zero     <= (bus.din1 == '0);
            r_work     <= w_abs0;
            r_dmag     <= w_abs1;
            r_prem     <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_work <= {r_work[din0_WIDTH-2:0], w_fits};
          r_prem <= w_prem_next;
          r_cnt  <= r_cnt + 7'd1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_zero) begin
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
            r_rem  <= '0;
            r_quot <= r_sign0 ? Q_MIN : Q_MAX;
          end else begin
            r_dbz <= 1'b0;
            r_ovf <= w_ovf;
            r_rem <= w_rem_signed;
            if (w_ovf) begin
              r_quot <= w_qneg ? Q_MIN : Q_MAX;
            end else begin
              r_quot <= w_quot_signed;
            end
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quot        = r_quot;
  assign bus.rem         = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

endmodule
